score_keeper: RTL

Game-side producer of the score shown on the seven-segment display. It turns apple-eaten and collision events from the snake game logic into a saturating binary score and a matching two-digit BCD value for the display block. It also tracks a game-state machine, a per-session high score and a speed level. It runs entirely in the 50 MHz system clock domain.

---
 rtl/score_keeper_if.sv | 36 +++
 rtl/score_keeper.sv | 105 ++++++++++
 2 files changed

// File: rtl/score_keeper_if.sv
// rtl/score_keeper_if.sv - event inputs and score outputs between game logic and score keeper
interface score_keeper_if;
    logic       start;
    logic       apple_eaten;
    logic       hit;
    logic [3:0] score;
    logic [7:0] score_bcd;
    logic [3:0] high_score;
    logic [1:0] level;
    logic [1:0] state;
    logic       grow;

    modport master (
        output start,
        output apple_eaten,
        output hit,
        input  score,
        input  score_bcd,
        input  high_score,
        input  level,
        input  state,
        input  grow
    );

    modport slave (
        input  start,
        input  apple_eaten,
        input  hit,
        output score,
        output score_bcd,
        output high_score,
        output level,
        output state,
        output grow
    );
endinterface

// File: rtl/score_keeper.sv
// rtl/score_keeper.sv - saturating game score, BCD view, high score, speed level and game FSM
module score_keeper #(
    parameter int MAX_SCORE  = 13,
    parameter int LEVEL_STEP = 4
) (
    input  logic          clk_50MHz,
    input  logic          rst,
    score_keeper_if.slave sk
);
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        WIN  = 2'b10,
        DEAD = 2'b11
    } state_t;

    localparam logic [3:0] MAX_S  = 4'(MAX_SCORE);
    localparam logic [3:0] STEP_S = 4'(LEVEL_STEP);

    state_t     state_q, state_d;
    logic [3:0] score_q, score_d;
    logic [3:0] high_q, high_d;
    logic       grow_q, grow_d;
    logic       start_prev_q, apple_prev_q, hit_prev_q;

    logic       start_e, apple_e, hit_e;
    logic [3:0] score_inc;
    logic [3:0] final_score;

    assign start_e     = sk.start & ~start_prev_q;
    assign apple_e     = sk.apple_eaten & ~apple_prev_q;
    assign hit_e       = sk.hit & ~hit_prev_q;
    // Only used in PLAY, where score_q < MAX_S <= 15, so this never wraps.
    assign score_inc   = score_q + 4'd1;
    assign final_score = apple_e ? score_inc : score_q;

    // Prev registers load 1 on reset so a level held through reset is not an edge.
    always_ff @(posedge clk_50MHz) begin
        if (rst) begin
            state_q      <= IDLE;
            score_q      <= 4'd0;
            high_q       <= 4'd0;
            grow_q       <= 1'b0;
            start_prev_q <= 1'b1;
            apple_prev_q <= 1'b1;
            hit_prev_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            score_q      <= score_d;
            high_q       <= high_d;
            grow_q       <= grow_d;
            start_prev_q <= sk.start;
            apple_prev_q <= sk.apple_eaten;
            hit_prev_q   <= sk.hit;
        end
    end

    // A same-cycle apple counts before the hit is considered.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_e) state_d = PLAY;
            end
            PLAY: begin
                if (apple_e && score_inc == MAX_S) state_d = WIN;
                else if (hit_e)                    state_d = DEAD;
            end
            WIN, DEAD: begin
                if (start_e) state_d = PLAY;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        score_d = score_q;
        high_d  = high_q;
        grow_d  = 1'b0;
        if (state_q == PLAY) begin
            if (apple_e) begin
                score_d = score_inc;
                grow_d  = 1'b1;
            end
            if (state_d != PLAY && final_score > high_q) high_d = final_score;
        end else if (state_d == PLAY) begin
            score_d = 4'd0;
        end
    end

    logic       tens;
    logic [3:0] ones;
    logic [3:0] level_raw;

    assign tens      = (score_q >= 4'd10);
    assign ones      = score_q - (tens ? 4'd10 : 4'd0);
    assign level_raw = score_q / STEP_S;

    assign sk.score      = score_q;
    assign sk.score_bcd  = {3'b000, tens, ones};
    assign sk.high_score = high_q;
    assign sk.level      = (level_raw > 4'd3) ? 2'd3 : level_raw[1:0];
    assign sk.state      = state_q;
    assign sk.grow       = grow_q;
endmodule
